drink_order_requester: RTL and testbench

- Requesting side of the drink-code lookup interface. Takes a user drink selection, encodes it into the 4-bit drink code and presents it to the code database with an enable.
- Waits for the database's match indication, with a timeout. Reports a one-cycle result (success or error) to the machine controller.
- Keeps a saturating count of successful orders.

---
 rtl/drink_pkg.sv | 17 +
 rtl/wait_timer.sv | 17 +
 rtl/drink_order_requester.sv | 70 +++++++
 tb/tb_drink_order_requester.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/drink_pkg.sv
// drink_pkg: shared types, widths and drink code encoding for the drink order requester.
package drink_pkg;
   localparam int CODE_W  = 4;
   localparam int DRINK_W = 3;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
   localparam logic [DRINK_W-1:0] DRINK_WASSER     = 3'd0;
   localparam logic [DRINK_W-1:0] DRINK_COLA       = 3'd1;
   localparam logic [DRINK_W-1:0] DRINK_ORANGE     = 3'd2;
   localparam logic [DRINK_W-1:0] DRINK_ZITRONE    = 3'd3;
   localparam logic [DRINK_W-1:0] DRINK_TEE        = 3'd4;
   localparam logic [DRINK_W-1:0] DRINK_KAFFEE     = 3'd5;
   localparam logic [DRINK_W-1:0] DRINK_CAPPUCCINO = 3'd6;
   localparam logic [DRINK_W-1:0] DRINK_LATTE      = 3'd7;
   function automatic logic [CODE_W-1:0] encode_code(input logic extra, input logic [DRINK_W-1:0] drink);
      return {extra, drink};
   endfunction
endpackage

// File: rtl/wait_timer.sv
// wait_timer: cycle counter for the WAIT state with terminal count at TIMEOUT-1.
module wait_timer #(
   parameter int TIMEOUT = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       enable,
   output logic [7:0] count,
   output logic       tc
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (clear) count <= '0;
      else if (enable) count <= count + 8'd1;
   assign tc = count == 8'(TIMEOUT - 1);
endmodule

// File: rtl/drink_order_requester.sv
// drink_order_requester: encodes a drink selection, requests a database match with
// timeout and cancel, reports a one-cycle result and counts served orders.
module drink_order_requester
   import drink_pkg::*;
#(
   parameter int TIMEOUT = 20,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sel_valid,
   input  logic [DRINK_W-1:0] sel_drink,
   input  logic               sel_extra,
   output logic               sel_ready,
   input  logic               cancel,
   output logic               db_enable,
   output logic [CODE_W-1:0]  db_code,
   input  logic               db_done,
   output logic               order_valid,
   output logic               order_err,
   output logic [CODE_W-1:0]  order_code,
   output logic [CNT_W-1:0]   served_cnt
);
   state_t     state, next_state;
   logic [7:0] timer;
   logic       tc, accept, enable_d, valid_d, err_d;
   assign sel_ready = state == IDLE;
   assign accept    = sel_valid && sel_ready;
   wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state != WAIT),
      .enable (state == WAIT),
      .count  (timer),
      .tc     (tc)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         db_enable   <= 1'b0;
         db_code     <= '0;
         order_valid <= 1'b0;
         order_err   <= 1'b0;
         order_code  <= '0;
         served_cnt  <= '0;
      end else begin
         state       <= next_state;
         db_enable   <= enable_d;
         order_valid <= valid_d;
         order_err   <= err_d;
         if (accept) db_code <= encode_code(sel_extra, sel_drink);
         if (valid_d) order_code <= db_code;
         if (next_state == DONE && served_cnt != '1) served_cnt <= served_cnt + 1'b1;
      end
   // A done seen on the first WAIT cycle may be left over from a previous lookup.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: next_state = accept ? REQ : IDLE;
         REQ:  next_state = cancel ? IDLE : WAIT;
         WAIT: next_state = (db_done && timer != 8'd0) ? DONE : tc ? ERR : cancel ? IDLE : WAIT;
         default: next_state = IDLE;
      endcase
   end
   always_comb begin
      enable_d = next_state == REQ || next_state == WAIT;
      valid_d  = next_state == DONE || next_state == ERR;
      err_d    = next_state == ERR;
   end
endmodule

// File: tb/tb_drink_order_requester.sv
// tb_drink_order_requester: table-driven orders with a result scoreboard, plus reset corner cases.
module tb_drink_order_requester;
   localparam int NO = 99;
   logic       clk = 1'b0, rst_n = 1'b0, sel_valid = 1'b0, sel_extra = 1'b0, cancel = 1'b0, db_done = 1'b0;
   logic [2:0] sel_drink = 3'd0;
   logic       sel_ready, db_enable, order_valid, order_err;
   logic [3:0] db_code, order_code;
   logic [7:0] served_cnt;
   logic       s_sel_ready, s_db_enable, s_order_valid, s_order_err;
   logic [3:0] s_db_code, s_order_code;
   logic [1:0] s_served_cnt;
   drink_order_requester #(.TIMEOUT(20), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_drink(sel_drink), .sel_extra(sel_extra),
      .sel_ready(sel_ready), .cancel(cancel), .db_enable(db_enable), .db_code(db_code), .db_done(db_done),
      .order_valid(order_valid), .order_err(order_err), .order_code(order_code), .served_cnt(served_cnt)
   );
   drink_order_requester #(.TIMEOUT(20), .CNT_W(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_drink(sel_drink), .sel_extra(sel_extra),
      .sel_ready(s_sel_ready), .cancel(cancel), .db_enable(s_db_enable), .db_code(s_db_code), .db_done(db_done),
      .order_valid(s_order_valid), .order_err(s_order_err), .order_code(s_order_code), .served_cnt(s_served_cnt)
   );
   always #5 clk = ~clk;
   // kind: 0 success, 1 timeout error, 2 cancelled; exp_k is the WAIT cycle that ends the request (-1 = REQ)
   typedef struct {
      logic [2:0] drink;
      logic       extra;
      int         done_at;
      int         cancel_at;
      bit         stale;
      bit         spur;
      int         kind;
      int         exp_k;
      logic [3:0] exp_code;
   } vec_t;
   typedef struct {
      logic       err;
      logic [3:0] code;
      int         cnt;
   } exp_t;
   exp_t sbq[$];
   int   checks = 0, fails = 0, served = 0;
   bit   prev_valid = 1'b0;
   vec_t tbl[10];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && order_valid) begin
         if (prev_valid) chk("order_valid one cycle", 1, 0);
         if (sbq.size() == 0) chk("unexpected order_valid", 1, 0);
         else begin
            e = sbq.pop_front();
            chk("order_err", order_err, e.err);
            chk("order_code", order_code, e.code);
            chk("served_cnt", served_cnt, e.cnt);
            chk("small order_valid", s_order_valid, 1);
            chk("small served_cnt", s_served_cnt, e.cnt > 3 ? 3 : e.cnt);
         end
      end
      prev_valid = rst_n && order_valid;
   end
   task automatic run(input vec_t v);
      int k;
      bit gone;
      if (v.kind < 2) begin
         if (v.kind == 0) served++;
         sbq.push_back('{v.kind == 1, v.exp_code, served});
      end
      chk("sel_ready before accept", sel_ready, 1);
      sel_valid = 1'b1;
      sel_drink = v.drink;
      sel_extra = v.extra;
      db_done   = v.stale;
      @(posedge clk); #1;
      sel_valid = 1'b0;
      chk("db_enable on accept", db_enable, 1);
      chk("db_code on accept", db_code, v.exp_code);
      k = -1;
      gone = 1'b0;
      while (!gone && k < 40) begin
         db_done = (v.stale && k <= 0) || (k >= v.done_at);
         cancel  = k == v.cancel_at;
         if (v.spur && k == 2) begin
            sel_valid = 1'b1;
            sel_drink = 3'd2;
            sel_extra = 1'b0;
         end else sel_valid = 1'b0;
         @(posedge clk); #1;
         if (!db_enable) gone = 1'b1;
         else k++;
      end
      db_done = 1'b0;
      cancel = 1'b0;
      sel_valid = 1'b0;
      chk("request end cycle", k, v.exp_k);
      chk("db_code held", db_code, v.exp_code);
      if (v.kind < 2) begin
         chk("sel_ready in result cycle", sel_ready, 0);
         @(posedge clk); #1;
      end
      chk("sel_ready after request", sel_ready, 1);
   endtask
   initial begin
      tbl[0] = '{3'd5, 1'b1, 3,  NO, 1'b0, 1'b0, 0, 3,  4'hD};
      tbl[1] = '{3'd0, 1'b0, 1,  NO, 1'b0, 1'b0, 0, 1,  4'h0};
      tbl[2] = '{3'd7, 1'b1, 2,  NO, 1'b0, 1'b1, 0, 2,  4'hF};
      tbl[3] = '{3'd3, 1'b0, 5,  5,  1'b0, 1'b0, 0, 5,  4'h3};
      tbl[4] = '{3'd2, 1'b1, NO, 4,  1'b0, 1'b0, 2, 4,  4'hA};
      tbl[5] = '{3'd6, 1'b0, NO, NO, 1'b1, 1'b0, 1, 19, 4'h6};
      tbl[6] = '{3'd1, 1'b1, NO, -1, 1'b0, 1'b0, 2, -1, 4'h9};
      tbl[7] = '{3'd4, 1'b0, 19, NO, 1'b0, 1'b0, 0, 19, 4'h4};
      tbl[8] = '{3'd4, 1'b1, NO, NO, 1'b0, 1'b0, 1, 19, 4'hC};
      tbl[9] = '{3'd5, 1'b0, 10, 3,  1'b0, 1'b1, 2, 3,  4'h5};
      #12;
      chk("reset sel_ready", sel_ready, 1);
      chk("reset db_enable", db_enable, 0);
      chk("reset db_code", db_code, 0);
      chk("reset order_valid", order_valid, 0);
      chk("reset order_err", order_err, 0);
      chk("reset order_code", order_code, 0);
      chk("reset served_cnt", served_cnt, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) run(tbl[i]);
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      chk("idle cancel sel_ready", sel_ready, 1);
      chk("idle cancel db_enable", db_enable, 0);
      chk("served_cnt before reset", served_cnt, 5);
      sel_valid = 1'b1;
      sel_drink = 3'd0;
      sel_extra = 1'b1;
      @(posedge clk); #1;
      sel_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset db_enable", db_enable, 0);
      chk("async reset served_cnt", served_cnt, 0);
      chk("async reset small served_cnt", s_served_cnt, 0);
      chk("async reset sel_ready", sel_ready, 1);
      chk("async reset order_valid", order_valid, 0);
      served = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post reset sel_ready", sel_ready, 1);
      chk("post reset db_enable", db_enable, 0);
      run(tbl[0]);
      repeat (3) @(posedge clk);
      chk("scoreboard drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
